// File: rtl/measure_scheduler_pkg.sv
// Shared types and constants for the cursor-measurement scheduler and its multiplier.
package measure_pkg;

    localparam int CW_DEFAULT       = 11;
    localparam int RW_DEFAULT       = 14;
    localparam int OPW              = 7;   // operand width: sample_adjust+1 reaches 64
    localparam int MUL_ITER_DEFAULT = 7;
    localparam int RESULT_MAX       = 16383;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        MUL    = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MEAS_NONE = 2'd0,
        MEAS_DX   = 2'd1,
        MEAS_DY   = 2'd2,
        MEAS_RSVD = 2'd3
    } meas_t;

endpackage

// File: rtl/measure_scheduler_if.sv
// Request/settings bundle in, grant/result bundle out; one-cycle strobes, no backpressure on results.
interface measure_scheduler_if
    import measure_pkg::*;
#(
    parameter int CW = CW_DEFAULT,
    parameter int RW = RW_DEFAULT
);
    logic [1:0]    req;
    logic [1:0]    meas_type0;
    logic [1:0]    meas_type1;
    logic [CW-1:0] cursor_x1;
    logic [CW-1:0] cursor_x2;
    logic [CW-1:0] cursor_y1;
    logic [CW-1:0] cursor_y2;
    logic [3:0]    shift_down1;
    logic [3:0]    shift_down2;
    logic [5:0]    sample_adjust1;
    logic [5:0]    sample_adjust2;
    logic [1:0]    req_ack;
    logic          busy;
    logic [RW-1:0] result;
    logic          result_valid;
    logic          result_wave;
    logic          result_sat;

    modport master (
        output req, meas_type0, meas_type1,
        output cursor_x1, cursor_x2, cursor_y1, cursor_y2,
        output shift_down1, shift_down2, sample_adjust1, sample_adjust2,
        input  req_ack, busy, result, result_valid, result_wave, result_sat
    );

    modport slave (
        input  req, meas_type0, meas_type1,
        input  cursor_x1, cursor_x2, cursor_y1, cursor_y2,
        input  shift_down1, shift_down2, sample_adjust1, sample_adjust2,
        output req_ack, busy, result, result_valid, result_wave, result_sat
    );

endinterface

// File: rtl/measure_seq_mult.sv
// Shift-add multiplier, multiplier LSB first; product final ITER edges after start.
// done marks the cycle of the last iteration; start reloads at any time (no backpressure).
module measure_seq_mult
    import measure_pkg::*;
#(
    parameter int AW   = CW_DEFAULT,
    parameter int BW   = OPW,
    parameter int ITER = MUL_ITER_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    mcand,
    input  logic [BW-1:0]    mplier,
    output logic [AW+BW-1:0] product,
    output logic             done
);

    localparam int PW   = AW + BW;
    localparam int CNTW = $clog2(ITER + 1);

    logic [PW-1:0]   mc_q;
    logic [BW-1:0]   mp_q;
    logic [CNTW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            product <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            product <= '0;
            mc_q    <= PW'(mcand);
            mp_q    <= mplier;
            cnt_q   <= CNTW'(ITER);
        end else if (cnt_q != '0) begin
            if (mp_q[0]) begin
                product <= product + mc_q;
            end
            mc_q  <= mc_q << 1;
            mp_q  <= mp_q >> 1;
            cnt_q <= cnt_q - CNTW'(1);
        end
    end

    assign done = (cnt_q == CNTW'(1));

endmodule

// File: rtl/measure_scheduler.sv
// Round-robin scheduler sharing one multiplier between two waves; result_valid 9 edges after grant.
// Requests are ignored while busy and held levels are served later; results are strobed, not backpressured.
module measure_scheduler
    import measure_pkg::*;
#(
    parameter int CW       = CW_DEFAULT,
    parameter int RW       = RW_DEFAULT,
    parameter int MUL_ITER = MUL_ITER_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    measure_scheduler_if.slave bus
);

    localparam int PW = CW + OPW;
    localparam logic [PW:0] SAT_LIMIT = {{(PW + 1 - RW){1'b0}}, {RW{1'b1}}};

    typedef struct packed {
        meas_t         mtype;
        logic          wave;
        logic [CW-1:0] x1;
        logic [CW-1:0] x2;
        logic [CW-1:0] y1;
        logic [CW-1:0] y2;
        logic [3:0]    shift;
        logic [5:0]    sadj;
    } job_t;

    state_t         state_q, state_d;
    job_t           job_q;
    logic           last_wave_q;
    logic           grant, grant_wave;
    logic           mul_start, mul_done, finish;
    logic           is_dy;
    logic [CW:0]    diff;
    logic [CW-1:0]  delta;
    logic [OPW-1:0] operand;
    logic [PW-1:0]  product;
    logic [PW:0]    scaled;
    logic           sat;

    // Both requesting: the wave not granted last wins.
    always_comb begin
        grant_wave = 1'b0;
        case (bus.req)
            2'b10:   grant_wave = 1'b1;
            2'b11:   grant_wave = ~last_wave_q;
            default: grant_wave = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        mul_start = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    grant   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (job_q.mtype == MEAS_DX || job_q.mtype == MEAS_DY) begin
                    mul_start = 1'b1;
                    state_d   = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        is_dy   = (job_q.mtype == MEAS_DY);
        diff    = is_dy ? ({1'b0, job_q.y1} - {1'b0, job_q.y2})
                        : ({1'b0, job_q.x1} - {1'b0, job_q.x2});
        delta   = diff[CW] ? CW'(-diff) : diff[CW-1:0];
        operand = is_dy ? ({{(OPW - 4){1'b0}}, job_q.shift} + OPW'(1))
                        : ({{(OPW - 6){1'b0}}, job_q.sadj} + OPW'(1));
        // Delta-y reports peak-to-peak, hence the doubling.
        scaled  = is_dy ? {product, 1'b0} : {1'b0, product};
        sat     = (scaled > SAT_LIMIT);
    end

    measure_seq_mult #(
        .AW   (CW),
        .BW   (OPW),
        .ITER (MUL_ITER)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .mcand   (delta),
        .mplier  (operand),
        .product (product),
        .done    (mul_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            job_q            <= '0;
            last_wave_q      <= 1'b1;
            bus.req_ack      <= 2'b00;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.result_wave  <= 1'b0;
            bus.result_sat   <= 1'b0;
        end else begin
            bus.req_ack      <= 2'b00;
            bus.result_valid <= 1'b0;
            if (grant) begin
                bus.req_ack <= grant_wave ? 2'b10 : 2'b01;
                last_wave_q <= grant_wave;
                job_q <= '{
                    mtype: meas_t'(grant_wave ? bus.meas_type1 : bus.meas_type0),
                    wave:  grant_wave,
                    x1:    bus.cursor_x1,
                    x2:    bus.cursor_x2,
                    y1:    bus.cursor_y1,
                    y2:    bus.cursor_y2,
                    shift: grant_wave ? bus.shift_down2 : bus.shift_down1,
                    sadj:  grant_wave ? bus.sample_adjust2 : bus.sample_adjust1
                };
            end
            if (finish) begin
                bus.result       <= sat ? {RW{1'b1}} : scaled[RW-1:0];
                bus.result_sat   <= sat;
                bus.result_wave  <= job_q.wave;
                bus.result_valid <= 1'b1;
            end
        end
    end

    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_measure_scheduler.sv
// Scoreboard bench for measure_scheduler: expectations queued at grant, checked on result_valid.
module tb_measure_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_res    = 0;

    typedef struct {
        int res;
        bit wave;
        bit sat;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    measure_scheduler_if bus ();

    measure_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model(input int mt, input int x1, input int x2, input int y1,
                                  input int y2, input int sd, input int sa,
                                  output int r, output bit s);
        int p;
        p = 0;
        if (mt == 1) p = (x1 > x2 ? x1 - x2 : x2 - x1) * (sa + 1);
        else if (mt == 2) p = (y1 > y2 ? y1 - y2 : y2 - y1) * (sd + 1) * 2;
        s = (p > 16383);
        r = s ? 16383 : p;
    endfunction

    // Scoreboard side: every grant must be one-hot, every valid must match the queue head.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.req_ack !== 2'b00) begin
                vectors++;
                if (!$onehot(bus.req_ack)) begin
                    miscompares++;
                    $display("FAIL ack_onehot: got %b, need exactly one bit", bus.req_ack);
                end
            end
            if (bus.result_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid: result=%0d wave=%0d with no job pending",
                             bus.result, bus.result_wave);
                end else begin
                    e = sb.pop_front();
                    vectors++;
                    if (bus.result !== 14'(e.res)) begin
                        miscompares++;
                        $display("FAIL result: got %0d, expected %0d", bus.result, e.res);
                    end
                    vectors++;
                    if (bus.result_wave !== e.wave) begin
                        miscompares++;
                        $display("FAIL result_wave: got %0d, expected %0d", bus.result_wave, e.wave);
                    end
                    vectors++;
                    if (bus.result_sat !== e.sat) begin
                        miscompares++;
                        $display("FAIL result_sat: got %0d, expected %0d", bus.result_sat, e.sat);
                    end
                    vectors++;
                    if (cyc != e.due) begin
                        miscompares++;
                        $display("FAIL latency: valid at cycle %0d, expected cycle %0d", cyc, e.due);
                    end
                    vectors++;
                    if (bus.busy !== 1'b0) begin
                        miscompares++;
                        $display("FAIL busy_at_valid: got %0d, expected 0", bus.busy);
                    end
                end
            end
        end
    end

    // Returns on the negedge just after the grant edge, with req already dropped.
    task automatic do_job(input bit w, input int mt, input int x1, input int x2, input int y1,
                          input int y2, input int sd, input int sa);
        int r;
        bit s;
        bit got;
        @(negedge clk);
        bus.cursor_x1 = 11'(x1);
        bus.cursor_x2 = 11'(x2);
        bus.cursor_y1 = 11'(y1);
        bus.cursor_y2 = 11'(y2);
        if (w) begin
            bus.meas_type1     = 2'(mt);
            bus.shift_down2    = 4'(sd);
            bus.sample_adjust2 = 6'(sa);
        end else begin
            bus.meas_type0     = 2'(mt);
            bus.shift_down1    = 4'(sd);
            bus.sample_adjust1 = 6'(sa);
        end
        bus.req = w ? 2'b10 : 2'b01;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ack !== 2'b00) got = 1'b1;
        end
        bus.req = 2'b00;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL grant_timeout: wave %0d never acknowledged", w);
        end else begin
            if (bus.req_ack !== (w ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL grant_wave: got ack %b for wave %0d", bus.req_ack, w);
            end
            if (mt == 1 || mt == 2) begin
                model(mt, x1, x2, y1, y2, sd, sa, r, s);
                sb.push_back('{res: r, wave: w, sat: s, due: cyc + 9});
                last_res = r;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results still outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.req_ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack: got %b, expected 00", bus.req_ack); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0d, expected 0", bus.busy); end
        vectors++;
        if (bus.result !== 14'd0) begin miscompares++; $display("FAIL reset_result: got %0d, expected 0", bus.result); end
        vectors++;
        if (bus.result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0d, expected 0", bus.result_valid); end
        vectors++;
        if (bus.result_wave !== 1'b0) begin miscompares++; $display("FAIL reset_wave: got %0d, expected 0", bus.result_wave); end
        vectors++;
        if (bus.result_sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %0d, expected 0", bus.result_sat); end
    endtask

    task automatic test_basic();
        do_job(1'b0, 2, 0, 0, 100, 40, 3, 0);     // 60*4*2 = 480
        drain();
        do_job(1'b1, 1, 10, 250, 0, 0, 0, 5);     // 240*6 = 1440
        drain();
    endtask

    task automatic test_back_to_back();
        bit expw, got, ok;
        int prev, r;
        bit s;
        @(negedge clk);
        bus.meas_type0  = 2'd2;
        bus.meas_type1  = 2'd2;
        bus.cursor_y1   = 11'd500;
        bus.cursor_y2   = 11'd130;
        bus.shift_down1 = 4'd1;
        bus.shift_down2 = 4'd6;
        bus.req         = 2'b11;
        expw = 1'b0;
        prev = -1;
        ok   = 1'b1;
        for (int j = 0; j < 4 && ok; j++) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (bus.req_ack !== 2'b00) got = 1'b1;
            end
            if (j == 3 || !got) bus.req = 2'b00;
            vectors++;
            if (!got) begin
                miscompares++;
                $display("FAIL rr_timeout: grant %0d never arrived", j);
                ok = 1'b0;
            end else begin
                if (bus.req_ack !== (expw ? 2'b10 : 2'b01)) begin
                    miscompares++;
                    $display("FAIL rr_order: grant %0d got ack %b, expected wave %0d", j, bus.req_ack, expw);
                end
                if (prev >= 0) begin
                    vectors++;
                    if (cyc - prev != 10) begin
                        miscompares++;
                        $display("FAIL rr_spacing: got %0d cycles, expected 10", cyc - prev);
                    end
                end
                prev = cyc;
                model(2, 0, 0, 500, 130, expw ? 6 : 1, 0, r, s);
                sb.push_back('{res: r, wave: expw, sat: s, due: cyc + 9});
                last_res = r;
                expw = ~expw;
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bit got;
        @(negedge clk);
        bus.meas_type1     = 2'd1;
        bus.cursor_x1      = 11'd900;
        bus.cursor_x2      = 11'd20;
        bus.sample_adjust2 = 6'd7;
        bus.req            = 2'b10;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ack !== 2'b00) got = 1'b1;
        end
        bus.req = 2'b00;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL abort_grant: no ack within budget");
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_res = 0;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %0d, expected 0", bus.busy); end
        vectors++;
        if (bus.result !== 14'd0) begin miscompares++; $display("FAIL abort_result: got %0d, expected 0", bus.result); end
        vectors++;
        if (bus.result_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %0d, expected 0", bus.result_valid); end
        repeat (12) @(negedge clk);
        do_job(1'b1, 1, 700, 50, 0, 0, 0, 3);     // 650*4 = 2600
        drain();
    endtask

    task automatic test_saturation();
        do_job(1'b0, 2, 0, 0, 2047, 0, 15, 0);    // 65504 clips to 16383
        drain();
        do_job(1'b0, 2, 0, 0, 5, 5, 15, 0);       // zero delta
        drain();
    endtask

    task automatic test_input_hold();
        do_job(1'b0, 1, 300, 100, 0, 0, 0, 9);    // 200*10 = 2000
        for (int i = 0; i < 8; i++) begin
            bus.cursor_x1      = 11'($urandom_range(0, 2047));
            bus.cursor_x2      = 11'($urandom_range(0, 2047));
            bus.sample_adjust1 = 6'($urandom_range(0, 63));
            bus.meas_type0     = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_type_none();
        do_job(1'b0, 0, 1, 2, 3, 4, 5, 6);
        vectors++;
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL none_busy_grant: got %0d, expected 1", bus.busy); end
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL none_busy_after: got %0d, expected 0", bus.busy); end
        do_job(1'b1, 3, 400, 0, 0, 0, 0, 10);
        repeat (12) @(negedge clk);
        vectors++;
        if (bus.result !== 14'(last_res)) begin
            miscompares++;
            $display("FAIL none_result_held: got %0d, expected %0d", bus.result, last_res);
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.req            = 2'b00;
        bus.meas_type0     = 2'd0;
        bus.meas_type1     = 2'd0;
        bus.cursor_x1      = '0;
        bus.cursor_x2      = '0;
        bus.cursor_y1      = '0;
        bus.cursor_y2      = '0;
        bus.shift_down1    = '0;
        bus.shift_down2    = '0;
        bus.sample_adjust1 = '0;
        bus.sample_adjust2 = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        test_input_hold();
        test_type_none();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/measure_scheduler.md
Name: measure_scheduler

Overview:
- Sequencing controller for the cursor-measurement datapath.
- Shares one shift-add measurement engine between two wave channels, wave 0 and wave 1, using round-robin arbitration.
- For each grant it captures the cursor positions and that wave's scale settings, computes the scaled delta-x or delta-y, and returns a 14-bit result to the display/number-formatting logic with a one-cycle valid strobe.
- Replaces ad-hoc switch-selected measuring with an explicit request/acknowledge flow.

Parameters:
- CW, 11, cursor coordinate width
- RW, 14, result width
- MUL_ITER, 7, multiplier iterations; covers the widest multiplier, sample_adjust+1 ≤ 64

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  2  per-wave measurement request; level, held until acknowledged
- meas_type0  in  2  wave-0 measurement: 0 none, 1 delta-x, 2 delta-y pk-pk, 3 reserved (treated as 0)
- meas_type1  in  2  wave-1 measurement, same encoding
- cursor_x1, cursor_x2, cursor_y1, cursor_y2  in  CW each  cursor positions, shared by both waves
- shift_down1, shift_down2  in  4 each  vertical shrink per wave
- sample_adjust1, sample_adjust2  in  6 each  sample-rate divider per wave
- req_ack  out  2  one-cycle grant pulse, one-hot
- busy  out  1  engine occupied
- result  out  RW  last completed measurement
- result_valid  out  1  one-cycle strobe when result updates
- result_wave  out  1  wave index of result
- result_sat  out  1  result was clipped to 2^RW−1

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer favours wave 0.
- Reset mid-operation aborts the in-flight job: no ack, no valid, result cleared to 0.
- States and transitions:
  - IDLE → LOAD on grant.
  - LOAD → MUL.
  - MUL → FINISH after MUL_ITER cycles.
  - FINISH → IDLE.
- Grant at edge E0 (state IDLE, any req bit high):
  - Only one request: it wins.
  - Both requests: the wave not granted last wins.
  - At E0: req_ack[w] pulses for that cycle; meas_type, all four cursors, shift_down_w and sample_adjust_w are captured; busy=1.
  - The pointer updates only on a grant.
- Type 0 or 3 at grant: acknowledged, but no measurement is produced. The engine returns to IDLE at E0+1 with busy=0; result and result_valid are untouched.
- LOAD at E0+1:
  - delta = |a−b|, computed in CW+1 bits then truncated to CW bits. Delta-x uses the x cursors; delta-y uses the y cursors.
  - Multiplier operand: sample_adjust+1 (7 bits) for delta-x; shift_down+1 (zero-extended to 7 bits) for delta-y.
- MUL E0+2..E0+8: one shift-add iteration per cycle into an 18-bit accumulator, LSB of the multiplier first.
- FINISH at E0+9:
  - Delta-y: product is shifted left by 1 (pk-pk ×2).
  - Any value > 16383 is clipped to 16383 with result_sat=1; otherwise result_sat=0.
  - result, result_wave, result_sat and result_valid=1 are registered at E0+9. busy=0 from E0+9.
- Fixed latency: result_valid is visible exactly 9 edges after the grant edge.
- Back-to-back jobs: a new grant is possible at E0+10.
- Requests are ignored while busy; a held req is served later.
- Input changes after E0 do not affect the job in progress.
- A request deasserted before it is granted is simply dropped.

Decomposition:
- Shared package measure_pkg holds:
  - state enum (IDLE, LOAD, MUL, FINISH)
  - measurement-type codes
  - CW/RW defaults
  - RESULT_MAX = 16383
  - MUL_ITER
- One sub-module is natural: measure_seq_mult, the iterative shift-add multiplier with start/done. The scheduler owns arbitration, operand capture and saturation.

Test Plan:
- Reset, then req=01, meas_type0=2, y1=100, y2=40, shift_down1=3 → ack=01 at grant; result=480, wave 0, sat 0; valid exactly 9 edges later.
- req=10, meas_type1=1, x1=10, x2=250, sample_adjust2=5 → result=1440, result_wave=1; delta sign is ignored.
- req=11 held for 4 jobs, both delta-y → grants in the order 0, 1, 0, 1; ack never asserts both bits; valid pulses spaced 10 cycles.
- meas_type0=2, y1=2047, y2=0, shift_down1=15 → 65504 clipped to 16383, result_sat=1; then y1=y2=5 → result=0, sat=0.
- Reset asserted during the third MUL cycle → no valid; busy=0 and result=0 the next cycle; a following request completes normally with correct latency.
- meas_type0=0 with req=01 → ack pulse, busy for 1 cycle, no result_valid, previous result held; cursors changed during MUL of a valid job do not alter its result.
